ee457_mem_arb: RTL and testbench

Two-port arbiter and sequencer that lets the pipelined CPU's instruction-fetch port and data-memory port share one single-ported, fixed-latency memory. It sits between the CPU's imem/dmem interfaces and the unified memory. It serializes accesses with a fair two-way policy, drives the memory control strobes for the full access latency, and returns registered read data. Each CPU port gets a one-cycle acknowledge and a stall signal.

---
 rtl/ee457_mem_arb_if.sv | 33 +++
 rtl/ee457_mem_arb.sv | 119 +++++++++++
 tb/tb_ee457_mem_arb.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/ee457_mem_arb_if.sv
// Bus bundle between the CPU imem/dmem ports, the shared-memory arbiter and the unified memory.
// The slave modport is the arbiter; the master modport is the CPU-plus-memory environment.
interface ee457_mem_arb_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        i_stall;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        d_stall;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_rdata, i_ack, i_stall, d_rdata, d_ack, d_stall,
    output mem_addr, mem_wdata, mem_read, mem_write
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_rdata, i_ack, i_stall, d_rdata, d_ack, d_stall,
    input  mem_addr, mem_wdata, mem_read, mem_write
  );
endinterface

// File: rtl/ee457_mem_arb.sv
// Fair two-way arbiter/sequencer sharing one fixed-latency single-port memory between
// the instruction-fetch and data ports; registered read data and one-cycle acks.
module ee457_mem_arb #(
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  ee457_mem_arb_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACC_I, ACC_D} state_t;

  localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg;
  logic        last_d_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic        we_reg;
  logic [31:0] i_rdata_reg;
  logic [31:0] d_rdata_reg;
  logic        i_ack_reg;
  logic        d_ack_reg;

  logic i_elig, d_elig;
  logic grant_i, grant_d, done, busy;

  // A port is not eligible in its own ack cycle, so a held stale request is not re-served.
  assign i_elig = bus.i_req & ~i_ack_reg;
  assign d_elig = bus.d_req & ~d_ack_reg;
  assign busy   = (state_reg != IDLE);

  always_comb begin
    state_next = state_reg;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_elig && d_elig) begin
          if (last_d_reg) grant_i = 1'b1;
          else            grant_d = 1'b1;
        end else if (i_elig) begin
          grant_i = 1'b1;
        end else if (d_elig) begin
          grant_d = 1'b1;
        end
        if (grant_i)      state_next = ACC_I;
        else if (grant_d) state_next = ACC_D;
      end
      ACC_I, ACC_D: begin
        if (cnt_reg == LAST_CNT) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg     <= 4'd0;
      last_d_reg  <= 1'b0;
      addr_reg    <= 32'd0;
      wdata_reg   <= 32'd0;
      we_reg      <= 1'b0;
      i_rdata_reg <= 32'd0;
      d_rdata_reg <= 32'd0;
      i_ack_reg   <= 1'b0;
      d_ack_reg   <= 1'b0;
    end else begin
      i_ack_reg <= 1'b0;
      d_ack_reg <= 1'b0;
      if (grant_i) begin
        addr_reg   <= bus.i_addr;
        wdata_reg  <= 32'd0;
        we_reg     <= 1'b0;
        cnt_reg    <= 4'd0;
        last_d_reg <= 1'b0;
      end else if (grant_d) begin
        addr_reg   <= bus.d_addr;
        wdata_reg  <= bus.d_wdata;
        we_reg     <= bus.d_we;
        cnt_reg    <= 4'd0;
        last_d_reg <= 1'b1;
      end else if (busy) begin
        cnt_reg <= cnt_reg + 4'd1;
      end
      if (done) begin
        if (state_reg == ACC_I) begin
          i_ack_reg   <= 1'b1;
          i_rdata_reg <= bus.mem_rdata;
        end else begin
          d_ack_reg <= 1'b1;
          // Writes complete with an ack but leave the data read register untouched.
          if (!we_reg) d_rdata_reg <= bus.mem_rdata;
        end
      end
    end
  end

  // Strobes come straight from state so an asynchronous reset drops them at once.
  assign bus.mem_read  = busy & ~we_reg;
  assign bus.mem_write = busy & we_reg;
  assign bus.mem_addr  = addr_reg;
  assign bus.mem_wdata = wdata_reg;
  assign bus.i_rdata   = i_rdata_reg;
  assign bus.d_rdata   = d_rdata_reg;
  assign bus.i_ack     = i_ack_reg;
  assign bus.d_ack     = d_ack_reg;
  assign bus.i_stall   = bus.i_req & ~i_ack_reg;
  assign bus.d_stall   = bus.d_req & ~d_ack_reg;
endmodule

// File: tb/tb_ee457_mem_arb.sv
// Directed, table-driven bench for ee457_mem_arb at MEM_LAT=2; memory returns addr ^ 0x8C010044.
module tb_ee457_mem_arb;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ee457_mem_arb_if bus ();

  ee457_mem_arb #(.MEM_LAT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  assign bus.mem_rdata = bus.mem_addr ^ 32'h8C010044;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        e_rd;
    logic        e_wr;
    logic [31:0] e_addr;
    logic        e_iack;
    logic        e_dack;
    logic        e_istall;
    logic        e_dstall;
    logic [31:0] e_irdata;
    logic [31:0] e_drdata;
  } vec_t;

  localparam logic [31:0] A_I  = 32'h40;
  localparam logic [31:0] A_I2 = 32'h44;
  localparam logic [31:0] A_D  = 32'h100;
  localparam logic [31:0] A_D2 = 32'h104;
  localparam logic [31:0] A_W  = 32'h200;
  localparam logic [31:0] WD   = 32'hDEADBEEF;
  localparam logic [31:0] RI   = 32'h8C010004;
  localparam logic [31:0] RI2  = 32'h8C010000;
  localparam logic [31:0] RD   = 32'h8C010144;
  localparam logic [31:0] RD2  = 32'h8C010140;
  localparam logic [31:0] RD3  = 32'h8C01014C;

  vec_t vt [23];

  function automatic vec_t mk(
    input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
    input logic [31:0] da, input logic [31:0] dwd,
    input logic erd, input logic ewr, input logic [31:0] ea,
    input logic eia, input logic eda, input logic eis, input logic eds,
    input logic [31:0] eir, input logic [31:0] edr);
    vec_t v;
    v.i_req = ir;  v.i_addr = ia;  v.d_req = dr;  v.d_we = dw;
    v.d_addr = da; v.d_wdata = dwd;
    v.e_rd = erd;  v.e_wr = ewr;   v.e_addr = ea;
    v.e_iack = eia; v.e_dack = eda; v.e_istall = eis; v.e_dstall = eds;
    v.e_irdata = eir; v.e_drdata = edr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.i_req   = 1'b0;
    bus.i_addr  = 32'd0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'd0;
    bus.d_wdata = 32'd0;
  endtask

  initial begin
    int rd_cycles;
    bit got_ack;
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    drive_idle();

    // Tie from reset: D first, I granted in d_ack's cycle; held I request re-served once.
    vt[0]  = mk(1, A_I, 1, 0, A_D, 0,   0, 0, 32'd0, 0, 0, 1, 1, 32'd0, 32'd0);
    vt[1]  = mk(1, A_I, 1, 0, A_D, 0,   1, 0, A_D,   0, 0, 1, 1, 32'd0, 32'd0);
    vt[2]  = mk(1, A_I, 1, 0, A_D, 0,   1, 0, A_D,   0, 0, 1, 1, 32'd0, 32'd0);
    vt[3]  = mk(1, A_I, 0, 0, A_D, 0,   0, 0, A_D,   0, 1, 1, 0, 32'd0, RD);
    vt[4]  = mk(1, A_I, 0, 0, A_D, 0,   1, 0, A_I,   0, 0, 1, 0, 32'd0, RD);
    vt[5]  = mk(1, A_I, 0, 0, A_D, 0,   1, 0, A_I,   0, 0, 1, 0, 32'd0, RD);
    vt[6]  = mk(1, A_I, 0, 0, A_D, 0,   0, 0, A_I,   1, 0, 0, 0, RI, RD);
    vt[7]  = mk(1, A_I, 0, 0, A_D, 0,   0, 0, A_I,   0, 0, 1, 0, RI, RD);
    vt[8]  = mk(1, A_I, 0, 0, A_D, 0,   1, 0, A_I,   0, 0, 1, 0, RI, RD);
    vt[9]  = mk(1, A_I, 0, 0, A_D, 0,   1, 0, A_I,   0, 0, 1, 0, RI, RD);
    vt[10] = mk(0, A_I, 0, 0, A_D, 0,   0, 0, A_I,   1, 0, 0, 0, RI, RD);
    // D write: strobes for two cycles, d_rdata keeps its prior value.
    vt[11] = mk(0, A_I, 1, 1, A_W, WD,  0, 0, A_I,   0, 0, 0, 1, RI, RD);
    vt[12] = mk(0, A_I, 1, 1, A_W, WD,  0, 1, A_W,   0, 0, 0, 1, RI, RD);
    vt[13] = mk(0, A_I, 1, 1, A_W, WD,  0, 1, A_W,   0, 0, 0, 1, RI, RD);
    vt[14] = mk(0, A_I, 0, 0, A_W, WD,  0, 0, A_W,   0, 1, 0, 0, RI, RD);
    // Tie after a D grant goes to I first.
    vt[15] = mk(1, A_I2, 1, 0, A_D2, 0, 0, 0, A_W,   0, 0, 1, 1, RI, RD);
    vt[16] = mk(1, A_I2, 1, 0, A_D2, 0, 1, 0, A_I2,  0, 0, 1, 1, RI, RD);
    vt[17] = mk(1, A_I2, 1, 0, A_D2, 0, 1, 0, A_I2,  0, 0, 1, 1, RI, RD);
    vt[18] = mk(0, A_I2, 1, 0, A_D2, 0, 0, 0, A_I2,  1, 0, 0, 1, RI2, RD);
    vt[19] = mk(0, A_I2, 1, 0, A_D2, 0, 1, 0, A_D2,  0, 0, 0, 1, RI2, RD);
    vt[20] = mk(0, A_I2, 1, 0, A_D2, 0, 1, 0, A_D2,  0, 0, 0, 1, RI2, RD);
    vt[21] = mk(0, A_I2, 0, 0, A_D2, 0, 0, 0, A_D2,  0, 1, 0, 0, RI2, RD2);
    vt[22] = mk(0, A_I2, 0, 0, A_D2, 0, 0, 0, A_D2,  0, 0, 0, 0, RI2, RD2);

    // Reset applied with no clock edge yet: all outputs must be zero.
    #1 rst = 1'b1;
    #1;
    check("rst mem_read",  {31'd0, bus.mem_read},  32'd0);
    check("rst mem_write", {31'd0, bus.mem_write}, 32'd0);
    check("rst mem_addr",  bus.mem_addr,  32'd0);
    check("rst mem_wdata", bus.mem_wdata, 32'd0);
    check("rst i_rdata",   bus.i_rdata,   32'd0);
    check("rst d_rdata",   bus.d_rdata,   32'd0);
    check("rst acks",      {30'd0, bus.i_ack, bus.d_ack},     32'd0);
    check("rst stalls",    {30'd0, bus.i_stall, bus.d_stall}, 32'd0);
    $display("reset: outputs sampled before first clock edge");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      check($sformatf("idle%0d strobes", c), {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
    end
    $display("idle: 10 cycles without requests checked");

    for (int k = 0; k < 23; k++) begin
      @(negedge clk);
      bus.i_req   = vt[k].i_req;
      bus.i_addr  = vt[k].i_addr;
      bus.d_req   = vt[k].d_req;
      bus.d_we    = vt[k].d_we;
      bus.d_addr  = vt[k].d_addr;
      bus.d_wdata = vt[k].d_wdata;
      #1;
      check($sformatf("v%0d mem_read", k),  {31'd0, bus.mem_read},  {31'd0, vt[k].e_rd});
      check($sformatf("v%0d mem_write", k), {31'd0, bus.mem_write}, {31'd0, vt[k].e_wr});
      check($sformatf("v%0d mem_addr", k),  bus.mem_addr, vt[k].e_addr);
      if (vt[k].e_wr) check($sformatf("v%0d mem_wdata", k), bus.mem_wdata, vt[k].d_wdata);
      check($sformatf("v%0d i_ack", k),   {31'd0, bus.i_ack},   {31'd0, vt[k].e_iack});
      check($sformatf("v%0d d_ack", k),   {31'd0, bus.d_ack},   {31'd0, vt[k].e_dack});
      check($sformatf("v%0d i_stall", k), {31'd0, bus.i_stall}, {31'd0, vt[k].e_istall});
      check($sformatf("v%0d d_stall", k), {31'd0, bus.d_stall}, {31'd0, vt[k].e_dstall});
      check($sformatf("v%0d i_rdata", k), bus.i_rdata, vt[k].e_irdata);
      check($sformatf("v%0d d_rdata", k), bus.d_rdata, vt[k].e_drdata);
      $display("vec %0d: rd=%b wr=%b addr=%h iack=%b dack=%b irdata=%h drdata=%h",
               k, bus.mem_read, bus.mem_write, bus.mem_addr, bus.i_ack, bus.d_ack,
               bus.i_rdata, bus.d_rdata);
    end

    // Reset during C1 of a D read: strobe drops at once, no ack, fresh access afterwards.
    @(negedge clk);
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h108;
    @(negedge clk);
    #1;
    check("c1 mem_read", {31'd0, bus.mem_read}, 32'd1);
    check("c1 mem_addr", bus.mem_addr, 32'h108);
    #1 rst = 1'b1;
    #1;
    check("midrst mem_read", {31'd0, bus.mem_read}, 32'd0);
    check("midrst mem_addr", bus.mem_addr, 32'd0);
    check("midrst d_rdata",  bus.d_rdata,  32'd0);
    @(negedge clk);
    check("midrst d_ack", {31'd0, bus.d_ack}, 32'd0);
    rst = 1'b0;
    rd_cycles = 0;
    got_ack   = 1'b0;
    for (int c = 0; c < 20 && !got_ack; c++) begin
      #1;
      if (bus.mem_read) rd_cycles++;
      if (bus.d_ack) begin
        got_ack    = 1'b1;
        bus.d_req  = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    check("retry d_ack seen", {31'd0, got_ack}, 32'd1);
    check("retry read cycles", rd_cycles, 32'd2);
    check("retry d_rdata", bus.d_rdata, RD3);
    $display("midrst: read cycles=%0d ack=%b d_rdata=%h", rd_cycles, got_ack, bus.d_rdata);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
